// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, framing constants and baud divisor math for the UART
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;
  localparam int DATA_BITS = 8;
  localparam int OVERSAMPLE_DEF = 16;
  function automatic int baud_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: host-side byte handshake and error pulses of the UART receiver
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;
  modport master (output rx_data, rx_valid, frame_err, overrun, input rx_ack);
  modport slave  (input rx_data, rx_valid, frame_err, overrun, output rx_ack);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-clock tick every DIV clocks, restartable by a synchronous clear
module uart_baud_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt;
  assign tick = !clr && cnt == W'(DIV - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 16x oversampling, mid-bit sampling and valid/ack output holding
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input logic        clk,
  input logic        reset,
  input logic        rx,
  uart_rx_if.master  bus
);
  localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);
  state_t                 state, state_n;
  logic [SW-1:0]          scnt, scnt_n;
  logic [BW-1:0]          bcnt, bcnt_n;
  logic [DATA_BITS-1:0]   shift, shift_n, data_q;
  logic                   s1, rxs, clr, tick, good, ferr, commit, valid_q, ferr_q, ovr_q;
  uart_baud_tick #(.DIV(DIV)) u_tick (.clk(clk), .reset(reset), .clr(clr), .tick(tick));
  always_ff @(posedge clk or negedge reset)
    if (!reset) {s1, rxs} <= 2'b11;
    else {s1, rxs} <= {rx, s1};
  always_comb begin
    state_n = state;
    scnt_n  = scnt;
    bcnt_n  = bcnt;
    shift_n = shift;
    clr     = 1'b0;
    good    = 1'b0;
    ferr    = 1'b0;
    unique case (state)
      IDLE: if (!rxs) begin
        clr     = 1'b1;
        scnt_n  = '0;
        state_n = START;
      end
      START: if (tick) begin
        if (scnt != S_MID) scnt_n = scnt + 1'b1;
        else if (rxs) state_n = IDLE;
        else begin
          scnt_n  = '0;
          bcnt_n  = '0;
          state_n = DATA;
        end
      end
      DATA: if (tick) begin
        if (scnt != S_END) scnt_n = scnt + 1'b1;
        else begin
          shift_n = {rxs, shift[DATA_BITS-1:1]};
          scnt_n  = '0;
          bcnt_n  = bcnt + 1'b1;
          state_n = bcnt == B_END ? STOP : DATA;
        end
      end
      STOP: if (tick) begin
        if (scnt != S_END) scnt_n = scnt + 1'b1;
        else begin
          good    = rxs;
          ferr    = !rxs;
          state_n = rxs ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: state_n = rxs ? IDLE : WAIT_IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      scnt  <= '0;
      bcnt  <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      scnt  <= scnt_n;
      bcnt  <= bcnt_n;
      shift <= shift_n;
    end
  // A commit coinciding with an ack replaces the held byte instead of overrunning
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      commit  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      commit <= good;
      ferr_q <= ferr;
      ovr_q  <= commit && valid_q && !bus.rx_ack;
      if (commit && (!valid_q || bus.rx_ack)) begin
        data_q  <= shift;
        valid_q <= 1'b1;
      end else if (bus.rx_ack) valid_q <= 1'b0;
    end
  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART serial receiver for the UART peripheral, at the opposite end of the link from the transmitter. It samples the asynchronous rx line with a 16x oversampling baud tick derived from the system clock. It deframes 8N1 characters, LSB first, and presents each byte on a valid/ack holding interface to the host-side logic. Framing errors, false starts and overruns are detected and flagged.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 9600, line bit rate in bits/s
OVERSAMPLE, 16, sample ticks per bit; must be even and >= 8
DIV (localparam), CLK_FREQ/(BAUD*OVERSAMPLE), clocks per sample tick; integer floor; must be >= 2

Ports:
clk  input  1  system clock; all logic is on its rising edge
reset  input  1  asynchronous, active-low reset; 0 resets the block
rx  input  1  asynchronous serial line; idles high
rx_data  output  8  last good received byte
rx_valid  output  1  rx_data holds an unacknowledged byte
rx_ack  input  1  host consumed the byte; clears rx_valid
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: a good byte was dropped because rx_valid was still held

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; synchronizer flops=1; tick and bit counters=0; rx_data=8'h00; rx_valid=0; frame_err=0; overrun=0. A reset mid-frame abandons the frame with no flag. After release the block waits for a fresh falling edge.
- rx passes through a 2-flop synchronizer reset to 1. rxs denotes the synchronized value.
- Tick generator: counter 0..DIV-1; tick=1 for one clk when the counter wraps. A synchronous clear sets counter=0, and the next tick occurs DIV clocks later.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. A sample counter scnt runs 0..OVERSAMPLE-1 and a bit counter bcnt runs 0..7.
- IDLE: when rxs=0, clear the tick generator, set scnt=0 and go to START.
- START: on each tick scnt++. On the tick where scnt reaches OVERSAMPLE/2-1 (mid-bit), check rxs.
  - rxs=1: false start; return to IDLE with no flag.
  - rxs=0: set scnt=0, bcnt=0 and go to DATA.
- DATA: on the tick where scnt reaches OVERSAMPLE-1, shift rxs into shift[7] (right shift, LSB first), set scnt=0 and bcnt++. After bit 7, go to STOP.
- STOP: sample at scnt=OVERSAMPLE-1.
  - rxs=1: byte is good; go to IDLE.
  - rxs=0: pulse frame_err for one cycle; discard the byte, leaving rx_data and rx_valid unchanged; go to WAIT_IDLE.
- WAIT_IDLE: stay until rxs=1, then go to IDLE. A break condition therefore produces exactly one frame_err.
- Good-byte commit, in the cycle after the stop sample:
  - if rx_valid=0, or rx_ack=1 in that same cycle: rx_data<=shift, rx_valid<=1.
  - otherwise: rx_data unchanged, rx_valid stays 1, overrun pulses one cycle.
- rx_ack with rx_valid=1 and no commit in the same cycle: rx_valid<=0 on the next edge. rx_ack while rx_valid=0 is ignored.
- Latency: rx_valid rises OVERSAMPLE*DIV*9.5 clocks, plus 3 (±1), after the rx falling edge. The +3 is 2 synchronizer clocks plus 1 commit clock.
- Only 8N1 framing is supported: no parity, one stop bit. Sampling is single-sample at mid-bit, with no majority vote.
- Back-to-back frames: a start edge arriving immediately after the stop mid-sample is accepted, because IDLE is re-entered at mid-stop.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding constants (IDLE=0, START=1, DATA=2, STOP=3, WAIT_IDLE=4, 3 bits).
  - DATA_BITS=8 and OVERSAMPLE default.
  - A divisor helper so the transmitter and receiver share baud math.
- One sub-module, uart_baud_tick: parameter DIV, ports clk, reset, clr, tick. The transmitter can reuse it with OVERSAMPLE=1.

Test Plan:
All scenarios use CLK_FREQ=1600000, BAUD=10000, so DIV=10 and one bit = 160 clks.
1. Send 0xA5 (8N1) -> rx_valid rises 1520+3±1 clks after the start edge; rx_data=8'hA5; frame_err=0 and overrun=0 throughout.
2. Pulse rx low for 40 clks only -> no rx_valid, no frame_err; FSM back in IDLE; a following 0x3C is received correctly.
3. Send 0x55 with the stop bit held low, then release after 2 bit times -> frame_err is high for exactly 1 clk; rx_valid stays 0; a next frame 0x81 is received OK.
4. Send 0x11 then 0x22 back-to-back with no rx_ack -> rx_data stays 8'h11, rx_valid stays 1, overrun pulses once at the second commit. Repeat with rx_ack asserted on the commit cycle -> rx_data=8'h22 and no overrun.
5. Pull reset to 0 mid-DATA for 3 clks, then send 0xF0 -> outputs go to reset values immediately; 0xF0 is received correctly; the aborted frame gives no flags.
6. Stream 0x00..0xFF continuously, acking each byte 5 clks after rx_valid -> all 256 bytes received in order; no frame_err and no overrun.
